// File: rtl/fetch_unit.sv
// Sequential instruction fetch with branch redirect and a 2-entry in-order output buffer.
// Optional FETCH_TRAP_EN adds fetch_trap and a HALT state entered on a fetched 32'hDEAD_BEEF.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0100,
  parameter logic [31:0] PC_STEP  = 32'd8
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] PC,
  input  logic [31:0] instruction,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        if_ready,
  output logic        if_valid,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc
`ifdef FETCH_TRAP_EN
  ,
  output logic        fetch_trap
`endif
);

`ifdef FETCH_TRAP_EN
  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;
`else
  typedef enum logic {S_BOOT, S_RUN} state_t;
`endif

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_req_pc;
  logic        r_inflight;
  logic [1:0]  r_count;
  logic        r_head;
  logic [31:0] r_buf_pc  [2];
  logic [31:0] r_buf_ins [2];

  logic        w_pop;
  logic        w_push;
  logic        w_trap_hit;
  logic        w_issue;
  logic        w_tail;
  logic [1:0]  w_occ;

  assign PC       = r_pc;
  assign if_valid = (r_count != 2'd0);
  assign if_pc          = if_valid ? r_buf_pc[r_head]  : 32'h0;
  assign if_instruction = if_valid ? r_buf_ins[r_head] : 32'h0;

  assign w_pop  = if_valid & if_ready;
  assign w_tail = r_head ^ r_count[0];
  assign w_occ  = r_count + {1'b0, r_inflight};

`ifdef FETCH_TRAP_EN
  assign w_trap_hit = r_inflight & (instruction == 32'hDEAD_BEEF);
`else
  assign w_trap_hit = 1'b0;
`endif

  assign w_push = r_inflight & ~w_trap_hit;
  // Occupancy counts the in-flight word so a full buffer can never be pushed without a pop.
  assign w_issue = (r_state == S_RUN) & ~w_trap_hit &
                   ((w_occ < 2'd2) | ((w_occ == 2'd2) & w_pop));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_BOOT;
      r_pc       <= RESET_PC;
      r_req_pc   <= 32'h0;
      r_inflight <= 1'b0;
      r_count    <= 2'd0;
      r_head     <= 1'b0;
`ifdef FETCH_TRAP_EN
      fetch_trap <= 1'b0;
`endif
    end else if (branch_taken) begin
      r_state    <= S_RUN;
      r_pc       <= branch_target;
      r_inflight <= 1'b0;
      r_count    <= 2'd0;
      r_head     <= 1'b0;
`ifdef FETCH_TRAP_EN
      fetch_trap <= 1'b0;
`endif
    end else begin
      if (r_state == S_BOOT)
        r_state <= S_RUN;
`ifdef FETCH_TRAP_EN
      if (w_trap_hit) begin
        r_state    <= S_HALT;
        fetch_trap <= 1'b1;
      end
`endif
      r_count    <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      r_head     <= r_head ^ w_pop;
      r_inflight <= w_issue;
      if (w_issue) begin
        r_req_pc <= r_pc;
        r_pc     <= r_pc + PC_STEP;
      end
    end
  end

  // Storage has no reset; entries are only visible through the count.
  always_ff @(posedge clock) begin
    if (w_push && !branch_taken) begin
      r_buf_pc[w_tail]  <= r_req_pc;
      r_buf_ins[w_tail] <= instruction;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written corner sequences and a
// randomized run against a queue-based reference model. Honours FETCH_TRAP_EN.
module tb_fetch_unit;

  localparam logic [31:0] STEP = 32'd8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC;
  logic [31:0] instruction;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        if_ready;
  logic        if_valid;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;

  logic [31:0] pc2;
  logic        if_valid2;
  logic [31:0] if_instruction2;
  logic [31:0] if_pc2;

  logic [31:0] cache_addr;
  logic [31:0] beef_pc;

  int errors = 0;
  int checks = 0;

`ifdef FETCH_TRAP_EN
  logic fetch_trap;
  logic fetch_trap2;
`endif

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] beef);
    if (a == beef) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Synchronous-read cache: data for the PC seen at an edge arrives in the following cycle.
  always @(posedge clk) cache_addr <= PC;
  assign instruction = mem_word(cache_addr, beef_pc);

  fetch_unit dut (
    .clock(clk), .reset(reset), .PC(PC), .instruction(instruction),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .if_ready(if_ready), .if_valid(if_valid),
    .if_instruction(if_instruction), .if_pc(if_pc)
`ifdef FETCH_TRAP_EN
    , .fetch_trap(fetch_trap)
`endif
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clock(clk), .reset(reset), .PC(pc2), .instruction(32'h0),
    .branch_taken(1'b0), .branch_target(32'h0),
    .if_ready(1'b1), .if_valid(if_valid2),
    .if_instruction(if_instruction2), .if_pc(if_pc2)
`ifdef FETCH_TRAP_EN
    , .fetch_trap(fetch_trap2)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string name, input logic v, input logic [31:0] p);
    chk({name, ".if_valid"}, {31'b0, if_valid}, {31'b0, v});
    chk({name, ".if_pc"}, if_pc, v ? p : 32'h0);
    chk({name, ".if_instruction"}, if_instruction, v ? mem_word(p, beef_pc) : 32'h0);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    if_ready = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    #1;
    chk("reset.PC", PC, 32'h100);
    check_head("reset", 1'b0, 32'h0);
`ifdef FETCH_TRAP_EN
    chk("reset.fetch_trap", {31'b0, fetch_trap}, 32'h0);
`endif
    tick();
    reset = 1'b0;
  endtask

  // Reference model: pending fetch + queue of delivered-to-be entries.
  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
  ent_t        m_q[$];
  int          m_state;   // 0 boot, 1 run, 2 halt
  int          m_inflight;
  logic [31:0] m_pc;
  logic [31:0] m_req;
  int          m_trap;

  task automatic model_reset;
    m_q.delete();
    m_state = 0;
    m_inflight = 0;
    m_pc = 32'h100;
    m_req = 32'h0;
    m_trap = 0;
  endtask

  task automatic model_step;
    bit pop, hit, issue;
    int occ;
    pop = (m_q.size() != 0) && if_ready;
    if (branch_taken) begin
      m_pc = branch_target;
      m_q.delete();
      m_inflight = 0;
      m_state = 1;
      m_trap = 0;
    end else begin
      occ = m_q.size() + m_inflight;
      hit = 1'b0;
`ifdef FETCH_TRAP_EN
      hit = (m_inflight == 1) && (mem_word(m_req, beef_pc) == 32'hDEAD_BEEF);
`endif
      if (pop) void'(m_q.pop_front());
      if (m_inflight == 1 && !hit) m_q.push_back('{m_req, mem_word(m_req, beef_pc)});
      issue = (m_state == 1) && !hit && (occ < 2 || (occ == 2 && pop));
      if (m_state == 0) m_state = 1;
      if (hit) begin
        m_state = 2;
        m_trap = 1;
      end
      if (issue) begin
        m_req = m_pc;
        m_pc = m_pc + STEP;
        m_inflight = 1;
      end else begin
        m_inflight = 0;
      end
    end
  endtask

  task automatic model_check(input int cyc);
    string tag;
    tag = $sformatf("rand[%0d]", cyc);
    chk({tag, ".PC"}, PC, m_pc);
    chk({tag, ".depth_le2"}, {31'b0, m_q.size() <= 2}, 32'h1);
    if (m_q.size() != 0) check_head(tag, 1'b1, m_q[0].pc);
    else check_head(tag, 1'b0, 32'h0);
`ifdef FETCH_TRAP_EN
    chk({tag, ".fetch_trap"}, {31'b0, fetch_trap}, m_trap[31:0]);
`endif
  endtask

  typedef struct {
    logic        rdy;
    logic        br;
    logic [31:0] tgt;
    logic        exp_v;
    logic [31:0] exp_ifpc;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h100};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h108};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 32'h110};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 32'h110};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 32'h110};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h108, 32'h118};
    vecs[6]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h110, 32'h120};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h110, 32'h120};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h110, 32'h120};
    vecs[9]  = '{1'b1, 1'b1, 32'h140, 1'b0, 32'h0,   32'h140};
    vecs[10] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h148};
    vecs[11] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h140, 32'h150};
    vecs[12] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h148, 32'h158};

    beef_pc = 32'h1;
    reset = 1'b1;
    if_ready = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    tick();

    // Directed table: backpressure fill, drain in order, redirect with a full buffer.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      if_ready = vecs[i].rdy;
      branch_taken = vecs[i].br;
      branch_target = vecs[i].tgt;
      tick();
      chk($sformatf("vec[%0d].PC", i), PC, vecs[i].exp_pc);
      check_head($sformatf("vec[%0d]", i), vecs[i].exp_v, vecs[i].exp_ifpc);
      $display("vec %0d: rdy=%0b br=%0b PC=%h if_valid=%0b if_pc=%h",
               i, vecs[i].rdy, vecs[i].br, PC, if_valid, if_pc);
    end
    branch_taken = 1'b0;

    // Branch during BOOT, plus PC wraparound on the second instance.
    do_reset();
    if_ready = 1'b1;
    branch_taken = 1'b1;
    branch_target = 32'h200;
    tick();
    chk("bootbr.PC1", PC, 32'h200);
    chk("wrap.PC1", pc2, 32'hFFFF_FFF8);
    branch_taken = 1'b0;
    tick();
    chk("bootbr.PC2", PC, 32'h208);
    chk("wrap.PC2", pc2, 32'h0000_0000);
    tick();
    check_head("bootbr.e3", 1'b1, 32'h200);
    chk("wrap.if_pc1", if_pc2, 32'hFFFF_FFF8);
    tick();
    chk("wrap.if_pc2", if_pc2, 32'h0000_0000);
    $display("boot-branch/wrap: PC=%h wrap_if_pc=%h", PC, if_pc2);

    // Reset mid-operation with a full buffer discards everything immediately.
    do_reset();
    repeat (4) tick();
    chk("midrst.full", {31'b0, if_valid}, 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("midrst.PC", PC, 32'h100);
    check_head("midrst.async", 1'b0, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    if_ready = 1'b1;
    tick();
    check_head("midrst.e1", 1'b0, 32'h0);
    tick();
    check_head("midrst.e2", 1'b0, 32'h0);
    tick();
    check_head("midrst.e3", 1'b1, 32'h100);
    $display("mid-reset: if_valid=%0b if_pc=%h", if_valid, if_pc);

    // 32'hDEAD_BEEF returned for 0x108.
    do_reset();
    beef_pc = 32'h108;
    if_ready = 1'b1;
    repeat (3) tick();
    check_head("beef.e3", 1'b1, 32'h100);
    tick();
`ifdef FETCH_TRAP_EN
    check_head("trap.e4", 1'b0, 32'h0);
    chk("trap.set", {31'b0, fetch_trap}, 32'h1);
    chk("trap.PC_hold", PC, 32'h110);
    tick();
    check_head("trap.e5", 1'b0, 32'h0);
    chk("trap.PC_hold2", PC, 32'h110);
    beef_pc = 32'h1;
    branch_taken = 1'b1;
    branch_target = 32'h100;
    tick();
    branch_taken = 1'b0;
    chk("trap.clear", {31'b0, fetch_trap}, 32'h0);
    chk("trap.PC_redirect", PC, 32'h100);
    repeat (2) tick();
    check_head("trap.resume", 1'b1, 32'h100);
`else
    check_head("beef.e4", 1'b1, 32'h108);
    tick();
    check_head("beef.e5", 1'b1, 32'h110);
`endif
    $display("beef: if_valid=%0b if_pc=%h if_instruction=%h", if_valid, if_pc, if_instruction);

    // Randomized run against the reference model.
    beef_pc = 32'h1;
    do_reset();
    model_reset();
    for (int c = 0; c < 400; c++) begin
      if_ready = ($urandom_range(0, 9) < 7);
      branch_taken = ($urandom_range(0, 19) == 0);
      branch_target = $urandom() & 32'hFFFF_FFF8;
      model_step();
      tick();
      model_check(c);
    end
    branch_taken = 1'b0;
    $display("random: 400 cycles, PC=%h", PC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
